// File: rtl/afe_serial_writer.sv
// Serial write engine for the AFE configuration port: shifts one command word
// MSB-first over afe_sen / afe_sclk / afe_sdata with setup, hold and gap timing.
module afe_serial_writer #(
  parameter int DATA_WIDTH = 20,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int GAP        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_transaction,
  input  logic [DATA_WIDTH-1:0] afe_command,
  output logic                  ready,
  output logic                  afe_sen,
  output logic                  afe_sclk,
  output logic                  afe_sdata
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  ready_q, ready_d;
  logic                  sen_q, sen_d;
  logic                  sclk_q, sclk_d;
  logic                  sdata_q, sdata_d;

  // cnt_q counts cycles spent in the current state and restarts on every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (start_transaction) begin
          state_d = S_SETUP;
          shift_d = afe_command;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_SHIFT_LO;
          cnt_d   = '0;
        end
      end
      S_SHIFT_LO: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT_HI;
          cnt_d   = '0;
        end
      end
      S_SHIFT_HI: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            // No shift here so the LSB stays on afe_sdata through HOLD.
            state_d = S_HOLD;
          end else begin
            state_d = S_SHIFT_LO;
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q << 1;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the pins change on the same
  // edge as the state register.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    sen_d   = 1'b1;
    sclk_d  = 1'b0;
    sdata_d = 1'b0;
    case (state_d)
      S_SETUP, S_SHIFT_LO, S_HOLD: begin
        sen_d   = 1'b0;
        sdata_d = shift_d[DATA_WIDTH-1];
      end
      S_SHIFT_HI: begin
        sen_d   = 1'b0;
        sclk_d  = 1'b1;
        sdata_d = shift_d[DATA_WIDTH-1];
      end
      default: begin
        sen_d   = 1'b1;
        sdata_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ready_q <= 1'b1;
      sen_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      sen_q   <= sen_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
    end
  end

  assign ready     = ready_q;
  assign afe_sen   = sen_q;
  assign afe_sclk  = sclk_q;
  assign afe_sdata = sdata_q;

endmodule

// File: tb/tb_afe_serial_writer.sv
// Scoreboard bench for afe_serial_writer: a default-parameter instance and a
// minimum-timing instance, with a pin monitor that reassembles frames.
module tb_afe_serial_writer;

  localparam int DW = 20;
  // Default instance timing
  localparam int A_DIV = 4, A_SETUP = 2, A_HOLD = 2, A_GAP = 4;
  localparam int A_BUSY  = A_SETUP + 2 * A_DIV * DW + A_HOLD + A_GAP;
  localparam int A_SENLO = A_SETUP + 2 * A_DIV * DW + A_HOLD;
  localparam int A_FIRST = A_SETUP + A_DIV;
  // Minimum-timing instance
  localparam int B_DIV = 1, B_SETUP = 1, B_HOLD = 1, B_GAP = 1;
  localparam int B_BUSY  = B_SETUP + 2 * B_DIV * DW + B_HOLD + B_GAP;
  localparam int B_SENLO = B_SETUP + 2 * B_DIV * DW + B_HOLD;
  localparam int B_FIRST = B_SETUP + B_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0;
  logic          ready_a, sen_a, sclk_a, sdata_a;
  logic          ready_b, sen_b, sclk_b, sdata_b;

  afe_serial_writer #(.DATA_WIDTH(DW), .CLK_DIV(A_DIV), .CS_SETUP(A_SETUP),
                      .CS_HOLD(A_HOLD), .GAP(A_GAP)) dut_a (
    .clk(clk), .reset(reset), .start_transaction(start_a), .afe_command(cmd_a),
    .ready(ready_a), .afe_sen(sen_a), .afe_sclk(sclk_a), .afe_sdata(sdata_a));

  afe_serial_writer #(.DATA_WIDTH(DW), .CLK_DIV(B_DIV), .CS_SETUP(B_SETUP),
                      .CS_HOLD(B_HOLD), .GAP(B_GAP)) dut_b (
    .clk(clk), .reset(reset), .start_transaction(start_b), .afe_command(cmd_b),
    .ready(ready_b), .afe_sen(sen_b), .afe_sclk(sclk_b), .afe_sdata(sdata_b));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            dut;
    logic [DW-1:0] word;
    int            nedges;
    int            first_rise;
    int            sen_low;
    int            gap_before;
    bit            spacing_bad;
  } frame_t;

  typedef struct {
    int            dut;
    logic [DW-1:0] word;
  } exp_t;

  frame_t obs_q[$];
  exp_t   exp_q[$];

  // Pin monitor: rebuilds each word from afe_sdata at afe_sclk rising edges.
  wire [1:0] w_sen   = {sen_b, sen_a};
  wire [1:0] w_sclk  = {sclk_b, sclk_a};
  wire [1:0] w_sdata = {sdata_b, sdata_a};
  logic [1:0]    p_sen, p_sclk;
  bit   [1:0]    in_frame;
  logic [DW-1:0] m_word[2];
  int            m_edges[2], m_fall[2], m_first[2], m_last[2], m_rise[2], m_gap[2];
  bit   [1:0]    m_bad;
  frame_t        mfr;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        in_frame[d] = 1'b0;
        p_sen[d]    = 1'b1;
        p_sclk[d]   = 1'b0;
        m_rise[d]   = -1;
      end else begin
        if (p_sen[d] && !w_sen[d]) begin
          in_frame[d] = 1'b1;
          m_word[d]   = '0;
          m_edges[d]  = 0;
          m_fall[d]   = cyc;
          m_first[d]  = -1;
          m_bad[d]    = 1'b0;
          m_gap[d]    = (m_rise[d] < 0) ? -1 : cyc - m_rise[d];
        end
        if (in_frame[d] && !p_sclk[d] && w_sclk[d]) begin
          m_word[d] = {m_word[d][DW-2:0], w_sdata[d]};
          if (m_edges[d] == 0) m_first[d] = cyc - m_fall[d];
          else if (cyc - m_last[d] != ((d == 0) ? 2 * A_DIV : 2 * B_DIV)) m_bad[d] = 1'b1;
          m_last[d]  = cyc;
          m_edges[d] = m_edges[d] + 1;
        end
        if (!p_sen[d] && w_sen[d]) begin
          m_rise[d] = cyc;
          if (in_frame[d]) begin
            mfr.dut         = d;
            mfr.word        = m_word[d];
            mfr.nedges      = m_edges[d];
            mfr.first_rise  = m_first[d];
            mfr.sen_low     = cyc - m_fall[d];
            mfr.gap_before  = m_gap[d];
            mfr.spacing_bad = m_bad[d];
            obs_q.push_back(mfr);
            in_frame[d] = 1'b0;
          end
        end
        p_sen[d]  = w_sen[d];
        p_sclk[d] = w_sclk[d];
      end
    end
  end

  task automatic drive(input int d, input logic s, input logic [DW-1:0] c);
    if (d == 0) begin start_a = s; cmd_a = c; end
    else begin start_b = s; cmd_b = c; end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? ready_a : ready_b;
  endfunction

  task automatic wait_ready(input int d);
    int guard = 0;
    @(negedge clk);
    while (rdy(d) !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Sends one word; busy returns the number of cycles ready stayed low.
  // Extra one-cycle start pulses are injected at busy cycles p1 and p2.
  task automatic send(input int d, input logic [DW-1:0] w, input int p1, input int p2,
                      output int busy);
    int guard = 0;
    wait_ready(d);
    drive(d, 1'b1, w);
    exp_q.push_back('{d, w});
    @(posedge clk); #1;
    drive(d, 1'b0, DW'($urandom));
    busy = 0;
    @(negedge clk);
    while (rdy(d) === 1'b0 && guard < 2000) begin
      busy++;
      drive(d, (busy == p1 || busy == p2), DW'($urandom));
      @(negedge clk);
      guard++;
    end
    drive(d, 1'b0, '0);
  endtask

  task automatic pop_frame(output frame_t f, output exp_t e, output bit ok);
    f = '{default: 0};
    e = '{default: 0};
    ok = (obs_q.size() > 0) && (exp_q.size() > 0);
    if (obs_q.size() > 0) f = obs_q.pop_front();
    if (exp_q.size() > 0) e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({ready_a, sen_a, sclk_a, sdata_a} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_a cycle %0d: got %b expected 1100", i, {ready_a, sen_a, sclk_a, sdata_a});
      end
      checks++;
      if ({ready_b, sen_b, sclk_b, sdata_b} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_b cycle %0d: got %b expected 1100", i, {ready_b, sen_b, sclk_b, sdata_b});
      end
    end
    $display("test_reset: idle outputs checked for 5 cycles");
  endtask

  task automatic test_single_word();
    int busy; frame_t f; exp_t e; bit ok;
    send(0, 20'hA5C3F, -1, -1, busy);
    pop_frame(f, e, ok);
    checks++; if (busy !== A_BUSY) begin failures++; $display("FAIL single_busy: got %0d expected %0d", busy, A_BUSY); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_frame: got none expected one frame"); end
    checks++; if (f.word !== e.word) begin failures++; $display("FAIL single_word: got %h expected %h", f.word, e.word); end
    checks++; if (f.nedges !== DW) begin failures++; $display("FAIL single_edges: got %0d expected %0d", f.nedges, DW); end
    checks++; if (f.first_rise !== A_FIRST) begin failures++; $display("FAIL single_first_rise: got %0d expected %0d", f.first_rise, A_FIRST); end
    checks++; if (f.sen_low !== A_SENLO) begin failures++; $display("FAIL single_sen_low: got %0d expected %0d", f.sen_low, A_SENLO); end
    checks++; if (f.spacing_bad !== 1'b0) begin failures++; $display("FAIL single_spacing: got irregular expected %0d-cycle spacing", 2 * A_DIV); end
    $display("test_single_word: word=%h busy=%0d edges=%0d sen_low=%0d", f.word, busy, f.nedges, f.sen_low);
  endtask

  task automatic test_busy_start();
    int busy; int bad = 0; frame_t f; exp_t e; bit ok;
    send(0, 20'h00001, 10, 100, busy);
    checks++; if (busy !== A_BUSY) begin failures++; $display("FAIL busy_start_busy: got %0d expected %0d", busy, A_BUSY); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_a !== 1'b1 || sen_a !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL busy_start_queued: got %0d busy cycles expected 0", bad); end
    checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL busy_start_frames: got %0d expected 1", obs_q.size()); end
    pop_frame(f, e, ok);
    checks++; if (ok !== 1'b1 || f.word !== e.word || f.nedges !== DW) begin
      failures++; $display("FAIL busy_start_word: got %h/%0d edges expected %h/%0d", f.word, f.nedges, e.word, DW);
    end
    send(0, 20'hFFFFF, -1, -1, busy);
    pop_frame(f, e, ok);
    checks++; if (ok !== 1'b1 || f.word !== e.word || f.nedges !== DW) begin
      failures++; $display("FAIL busy_start_next: got %h/%0d edges expected %h/%0d", f.word, f.nedges, e.word, DW);
    end
    $display("test_busy_start: in-flight word=00001, next word=%h", f.word);
  endtask

  task automatic test_back_to_back();
    int busy1 = 0, busy2 = 0, guard = 0; frame_t f1, f2; exp_t e1, e2; bit ok1, ok2;
    wait_ready(0);
    drive(0, 1'b1, 20'h12345);
    exp_q.push_back('{0, 20'h12345});
    @(posedge clk); #1;
    drive(0, 1'b1, 20'h6789A);
    exp_q.push_back('{0, 20'h6789A});
    @(negedge clk);
    while (ready_a === 1'b0 && guard < 2000) begin busy1++; guard++; @(negedge clk); end
    @(posedge clk); #1;
    drive(0, 1'b0, DW'($urandom));
    guard = 0;
    @(negedge clk);
    while (ready_a === 1'b0 && guard < 2000) begin busy2++; guard++; @(negedge clk); end
    pop_frame(f1, e1, ok1);
    pop_frame(f2, e2, ok2);
    checks++; if (busy1 !== A_BUSY || busy2 !== A_BUSY) begin failures++; $display("FAIL b2b_busy: got %0d,%0d expected %0d", busy1, busy2, A_BUSY); end
    checks++; if (ok1 !== 1'b1 || f1.word !== e1.word || f1.nedges !== DW) begin
      failures++; $display("FAIL b2b_word1: got %h/%0d edges expected %h/%0d", f1.word, f1.nedges, e1.word, DW);
    end
    checks++; if (ok2 !== 1'b1 || f2.word !== e2.word || f2.nedges !== DW) begin
      failures++; $display("FAIL b2b_word2: got %h/%0d edges expected %h/%0d", f2.word, f2.nedges, e2.word, DW);
    end
    // afe_sen stays high through GAP plus the single ready cycle that accepts the next word.
    checks++; if (f2.gap_before !== A_GAP + 1) begin failures++; $display("FAIL b2b_sen_high: got %0d expected %0d", f2.gap_before, A_GAP + 1); end
    $display("test_back_to_back: words=%h,%h sen_high=%0d", f1.word, f2.word, f2.gap_before);
  endtask

  task automatic test_reset_mid_word();
    int busy, rises = 0, guard = 0; logic prev; frame_t f; exp_t e; bit ok;
    wait_ready(0);
    drive(0, 1'b1, 20'hFFFFF);
    exp_q.push_back('{0, 20'hFFFFF});
    @(posedge clk); #1;
    drive(0, 1'b0, '0);
    prev = sclk_a;
    while (rises < 8 && guard < 2000) begin
      @(negedge clk);
      if (!prev && sclk_a) rises++;
      prev = sclk_a;
      guard++;
    end
    reset = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    checks++; if ({ready_a, sen_a, sclk_a, sdata_a} !== 4'b1100) begin
      failures++; $display("FAIL mid_reset_outputs: got %b expected 1100", {ready_a, sen_a, sclk_a, sdata_a});
    end
    @(negedge clk);
    checks++; if (sclk_a !== 1'b0 || sen_a !== 1'b1) begin failures++; $display("FAIL mid_reset_hold: got sclk=%b sen=%b expected 0/1", sclk_a, sen_a); end
    reset = 1'b0;
    send(0, 20'h0F0F0, -1, -1, busy);
    pop_frame(f, e, ok);
    checks++; if (ok !== 1'b1 || f.word !== e.word || f.nedges !== DW || busy !== A_BUSY) begin
      failures++; $display("FAIL mid_reset_next: got %h/%0d edges/%0d busy expected %h/%0d/%0d", f.word, f.nedges, busy, e.word, DW, A_BUSY);
    end
    $display("test_reset_mid_word: aborted at bit 7, next word=%h", f.word);
  endtask

  task automatic test_min_timing();
    int busy; frame_t f; exp_t e; bit ok;
    send(1, 20'h80001, -1, -1, busy);
    pop_frame(f, e, ok);
    checks++; if (busy !== B_BUSY) begin failures++; $display("FAIL min_busy: got %0d expected %0d", busy, B_BUSY); end
    checks++; if (ok !== 1'b1 || f.dut !== 1 || f.word !== e.word) begin failures++; $display("FAIL min_word: got %h expected %h", f.word, e.word); end
    checks++; if (f.nedges !== DW) begin failures++; $display("FAIL min_edges: got %0d expected %0d", f.nedges, DW); end
    checks++; if (f.first_rise !== B_FIRST) begin failures++; $display("FAIL min_first_rise: got %0d expected %0d", f.first_rise, B_FIRST); end
    checks++; if (f.sen_low !== B_SENLO) begin failures++; $display("FAIL min_sen_low: got %0d expected %0d", f.sen_low, B_SENLO); end
    checks++; if (f.spacing_bad !== 1'b0) begin failures++; $display("FAIL min_toggle: got irregular expected sclk toggling every cycle"); end
    $display("test_min_timing: word=%h busy=%0d", f.word, busy);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_busy_start();
    test_back_to_back();
    test_reset_mid_word();
    test_min_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
